// File: rtl/test_aggregator_pkg.sv
// Shared types and elaboration helpers for the test session aggregator.
package test_aggregator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // A single channel still needs a one-bit index port.
    function automatic int idx_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic logic [63:0] cnt_max(input int width);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < width && i < 64; i++) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/test_channel_tracker.sv
// Sticky done/fail flags for one test channel, cleared at session start.
module test_channel_tracker (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic ch_done,
    input  logic ch_result,
    output logic done_q,
    output logic fail_q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (en) begin
            done_q <= done_q | ch_done;
            fail_q <= fail_q | ch_result;
        end
    end

endmodule

// File: rtl/test_aggregator.sv
// Start-triggered test session aggregator with sticky masks, timeout and verdict.
// Optional: define TEST_AGGREGATOR_ABORT_ON_FAIL_EN to end the session on the first failure.
module test_aggregator
    import test_aggregator_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16,
    localparam int IDX_W         = idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_result,
    input  logic [NUM_CH-1:0] ch_done,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timed_out,
    output logic [NUM_CH-1:0] fail_mask,
    output logic [NUM_CH-1:0] done_mask,
    output logic              first_fail_valid,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic             in_run, session_start;
    logic             all_done, any_fail, abort_fire, timeout_fire, verdict_pass;
    logic [IDX_W-1:0] lowest_idx;

    assign in_run        = (state == ST_RUN);
    assign session_start = start && !in_run;
    assign all_done      = &(done_mask | ch_done);
    assign any_fail      = |ch_result;

`ifdef TEST_AGGREGATOR_ABORT_ON_FAIL_EN
    assign abort_fire = in_run && any_fail;
`else
    assign abort_fire = 1'b0;
`endif

    // Completion and abort both outrank the timeout.
    assign timeout_fire = in_run && (cycle_count == TO_LAST) && !all_done && !abort_fire;
    assign verdict_pass = ~|(fail_mask | ch_result) & ~timeout_fire;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_trk
        test_channel_tracker u_trk (
            .clk       (clk),
            .reset     (reset),
            .clear     (session_start),
            .en        (in_run),
            .ch_done   (ch_done[g]),
            .ch_result (ch_result[g]),
            .done_q    (done_mask[g]),
            .fail_q    (fail_mask[g])
        );
    end

    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_result[i]) lowest_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FINISH: if (start) state_nxt = ST_RUN;
            ST_RUN: if (all_done || abort_fire || timeout_fire) state_nxt = ST_FINISH;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail             <= 1'b0;
            timed_out        <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            cycle_count      <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_FINISH);
            if (session_start) begin
                pass             <= 1'b0;
                fail             <= 1'b0;
                timed_out        <= 1'b0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= '0;
                cycle_count      <= '0;
            end else if (in_run) begin
                if (cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
                if (any_fail && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= lowest_idx;
                end
                // Verdict is frozen on the RUN -> FINISH edge.
                if (state_nxt == ST_FINISH) begin
                    timed_out <= timeout_fire;
                    pass      <= verdict_pass;
                    fail      <= ~verdict_pass;
                end
            end
        end
    end

endmodule

// File: tb/tb_test_aggregator.sv
// Scoreboard bench: a 2-channel instance (timeout 20) and a 4-channel instance.
module tb_test_aggregator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 2-channel instance
    logic        start2 = 1'b0;
    logic [1:0]  ch_result2 = '0, ch_done2 = '0;
    logic        busy2, done2, pass2, fail2, to2, ffv2;
    logic [1:0]  fm2, dm2;
    logic [0:0]  ffi2;
    logic [15:0] cc2;

    test_aggregator #(.NUM_CH(2), .TIMEOUT_CYCLES(20), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ch_result(ch_result2), .ch_done(ch_done2),
        .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .timed_out(to2),
        .fail_mask(fm2), .done_mask(dm2), .first_fail_valid(ffv2), .first_fail_idx(ffi2),
        .cycle_count(cc2)
    );

    // 4-channel instance
    logic        start4 = 1'b0;
    logic [3:0]  ch_result4 = '0, ch_done4 = '0;
    logic        busy4, done4, pass4, fail4, to4, ffv4;
    logic [3:0]  fm4, dm4;
    logic [1:0]  ffi4;
    logic [15:0] cc4;

    test_aggregator #(.NUM_CH(4), .TIMEOUT_CYCLES(1000), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .ch_result(ch_result4), .ch_done(ch_done4),
        .busy(busy4), .done(done4), .pass(pass4), .fail(fail4), .timed_out(to4),
        .fail_mask(fm4), .done_mask(dm4), .first_fail_valid(ffv4), .first_fail_idx(ffi4),
        .cycle_count(cc4)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        pass, fail, to, ffv, ffi;
        logic [1:0]  fm, dm;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Per-RUN-cycle stimulus for the 2-channel sessions
    logic [1:0] sd  [0:63];
    logic [1:0] sr  [0:63];
    logic       sst [0:63];

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            sd[i] = '0; sr[i] = '0; sst[i] = 1'b0;
        end
    endtask

    // Drives one session and predicts its outcome with a cycle-level reference model.
    task automatic run2();
        exp_t       e;
        logic [1:0] m_dm, m_fm;
        logic [15:0] m_cnt;
        logic       m_ffv, m_ffi, comp, ab, tohit, fin;
        m_dm = '0; m_fm = '0; m_cnt = '0; m_ffv = 1'b0; m_ffi = 1'b0; fin = 1'b0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk("start_busy",  32'(busy2), 32'd1);
        chk("start_cnt",   32'(cc2),   32'd0);
        chk("start_dmask", 32'(dm2),   32'd0);
        chk("start_fmask", 32'(fm2),   32'd0);
        for (int k = 0; k < 64 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            ch_done2 = sd[k]; ch_result2 = sr[k]; start2 = sst[k];
            comp = ((m_dm | sd[k]) == 2'b11);
`ifdef TEST_AGGREGATOR_ABORT_ON_FAIL_EN
            ab = !comp && (sr[k] != 2'b00);
`else
            ab = 1'b0;
`endif
            tohit = !comp && !ab && (m_cnt == 16'd19);
            if (sr[k] != 2'b00 && !m_ffv) begin
                m_ffv = 1'b1;
                m_ffi = sr[k][0] ? 1'b0 : 1'b1;
            end
            m_dm = m_dm | sd[k];
            m_fm = m_fm | sr[k];
            m_cnt = m_cnt + 16'd1;
            if (comp || ab || tohit) begin
                fin   = 1'b1;
                e.to  = tohit;
                e.pass = (m_fm == 2'b00) && !tohit;
                e.fail = !e.pass;
                e.fm = m_fm; e.dm = m_dm; e.ffv = m_ffv; e.ffi = m_ffi; e.cnt = m_cnt;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        ch_done2 = '0; ch_result2 = '0; start2 = 1'b0;
        chk("done_latency", 32'(done2), 32'd1);
        chk("finish_busy",  32'(busy2), 32'd0);
        clear_sched();
    endtask

    // Scoreboard: compare each completed session against the predicted record
    logic done2_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done2 && !done2_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pass",  32'(pass2), 32'(e.pass));
                chk("sb_fail",  32'(fail2), 32'(e.fail));
                chk("sb_to",    32'(to2),   32'(e.to));
                chk("sb_fmask", 32'(fm2),   32'(e.fm));
                chk("sb_dmask", 32'(dm2),   32'(e.dm));
                chk("sb_ffv",   32'(ffv2),  32'(e.ffv));
                chk("sb_ffi",   32'(ffi2),  32'(e.ffi));
                chk("sb_cnt",   32'(cc2),   32'(e.cnt));
            end
        end
        done2_q <= done2;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        clear_sched();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy2",  32'(busy2), 32'd0);
        chk("rst_done2",  32'(done2), 32'd0);
        chk("rst_pass2",  32'(pass2), 32'd0);
        chk("rst_fail2",  32'(fail2), 32'd0);
        chk("rst_to2",    32'(to2),   32'd0);
        chk("rst_masks2", 32'({fm2, dm2}), 32'd0);
        chk("rst_ff2",    32'({ffv2, ffi2}), 32'd0);
        chk("rst_cnt2",   32'(cc2),   32'd0);
        chk("rst_busy4",  32'(busy4), 32'd0);
        chk("rst_cnt4",   32'(cc4),   32'd0);

        // Clean pass: channel 0 at cycle 5, channel 1 at cycle 9
        sd[5] = 2'b01; sd[9] = 2'b10;
        run2();
        // New session straight from a passing FINISH; mixed failures
        sr[3] = 2'b10; sr[6] = 2'b01; sd[8] = 2'b11;
        run2();
        // Channel 1 never done -> timeout
        sd[2] = 2'b01;
        run2();
        // Last done on the final allowed cycle: completion beats timeout
        sd[2] = 2'b01; sd[19] = 2'b10;
        run2();
        // Already done at start
        sd[0] = 2'b11;
        run2();
        // start pulse during RUN is ignored
        sst[3] = 1'b1; sd[6] = 2'b11;
        run2();
        // Failure reported after a channel's done still counts
        sd[1] = 2'b01; sr[4] = 2'b01; sd[5] = 2'b10;
        run2();

        // 4-channel: reset in RUN cycle 7 aborts the session
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ch_done4   = (k == 1) ? 4'b0001 : 4'b0000;
            ch_result4 = (k == 2) ? 4'b1100 : 4'b0000;
            @(negedge clk);
        end
        ch_done4 = '0; ch_result4 = '0;
        chk("c4_cnt_pre",  32'(cc4),  32'd7);
        chk("c4_ffv_pre",  32'(ffv4), 32'd1);
        chk("c4_ffi_pre",  32'(ffi4), 32'd2);
        chk("c4_fm_pre",   32'(fm4),  32'hc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("c4_rst_busy", 32'(busy4), 32'd0);
        chk("c4_rst_done", 32'(done4), 32'd0);
        chk("c4_rst_cnt",  32'(cc4),   32'd0);
        chk("c4_rst_mask", 32'({fm4, dm4}), 32'd0);
        chk("c4_rst_ff",   32'({ffv4, ffi4}), 32'd0);
        // Fresh session
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        chk("c4_new_busy", 32'(busy4), 32'd1);
        chk("c4_new_cnt",  32'(cc4),   32'd0);
        for (int k = 0; k < 4; k++) begin
            ch_done4 = (k == 3) ? 4'b1111 : 4'b0000;
            @(negedge clk);
        end
        ch_done4 = '0;
        chk("c4_fin_done", 32'(done4), 32'd1);
        chk("c4_fin_pass", 32'(pass4), 32'd1);
        chk("c4_fin_cnt",  32'(cc4),   32'd4);
        chk("c4_fin_dm",   32'(dm4),   32'hf);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
